nodf_module_intf: RTL and testbench
===================================

NODF_MODULE_INTF -- requirements
Module: nodf_module_intf

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of every counter output.
REQ-002 SHALL have port clock, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port ap_start, input, 1 bit: start request of the observed non-dataflow module.
REQ-005 SHALL have port ap_ready, input, 1 bit: ready-for-new-input pulse of the observed module.
REQ-006 SHALL have port ap_done, input, 1 bit: completion pulse of the observed module.
REQ-007 SHALL have port ap_continue, input, 1 bit: downstream acknowledge; tie to 1 for modules without it.
REQ-008 SHALL have port finish, input, 1 bit: end-of-simulation request; freezes all statistics.
REQ-009 SHALL have port state, output, 2 bits: 0 IDLE, 1 RUN, 2 DONE_WAIT; 3 never driven.
REQ-010 SHALL have port start_cnt, output, CNT_W bits: number of accepted starts.
REQ-011 SHALL have port done_cnt, output, CNT_W bits: number of completed transactions.
REQ-012 SHALL have port ready_cnt, output, CNT_W bits: number of cycles with ap_ready=1 while not frozen.
REQ-013 SHALL have port busy_cycles, output, CNT_W bits: cycles spent in RUN or DONE_WAIT.
REQ-014 SHALL have port last_latency, output, CNT_W bits: latency of the most recent transaction.
REQ-015 SHALL have port max_latency, output, CNT_W bits: largest latency seen.
REQ-016 SHALL have port proto_err, output, 1 bit: sticky protocol-violation flag.
REQ-017 SHALL have port frozen, output, 1 bit: high once finish has been sampled.

Function
REQ-018 All outputs SHALL be registered; each value reflects inputs sampled at the previous rising edge.
REQ-019 IDLE, ap_start=1, ap_done=0: go to RUN; start_cnt+1; internal latency counter set to 1.
REQ-020 RUN, ap_done=0: latency counter +1 per cycle; busy_cycles +1.
REQ-021 RUN, ap_done=1: done_cnt+1; last_latency = latency counter + 1; max_latency updated if larger; go to IDLE if ap_continue=1, else DONE_WAIT.
REQ-022 DONE_WAIT: busy_cycles +1; go to IDLE on ap_continue=1; ap_done ignored here.
REQ-023 IDLE, ap_start=1 and ap_done=1 same cycle: start_cnt+1 and done_cnt+1, last_latency=1, stay IDLE if ap_continue=1, else DONE_WAIT.
REQ-024 ap_start=1 in RUN or DONE_WAIT SHALL NOT count as a new start (held start).
REQ-025 ap_done=1 in IDLE with ap_start=0 SHALL set proto_err; state unchanged.
REQ-026 ap_ready=1 in any state SHALL increment ready_cnt; ap_ready does not affect state.
REQ-027 All counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-028 finish=1 sampled: frozen=1 (sticky); from the next edge no counter, latency, proto_err or state update occurs; edge where finish is first sampled still updates normally.
REQ-029 Unused state encoding 3 SHALL recover to IDLE on the next edge.

Reset
REQ-030 reset=0 SHALL immediately force state=IDLE, every counter, last_latency, max_latency=0, proto_err=0, frozen=0, regardless of clock.
REQ-031 Reset asserted mid-transaction SHALL discard the transaction (no done counted); after release the block starts in IDLE.
REQ-032 Release of reset SHALL take effect on the first rising edge after reset=1.

Verification
REQ-033 Reset, then ap_start=1 1 cycle, ap_done=1 at 5th cycle after start, ap_continue=1 -> start_cnt=1, done_cnt=1, last_latency=5, max_latency=5, state IDLE.
REQ-034 Two transactions of latency 3 then 7 -> done_cnt=2, last_latency=7, max_latency=7; then latency 2 -> last_latency=2, max_latency=7.
REQ-035 ap_done with ap_continue=0 for 4 cycles then 1 -> state DONE_WAIT 4 cycles, busy_cycles includes them, then IDLE.
REQ-036 ap_done pulse while IDLE, no start -> proto_err=1, counts unchanged, stays 1 until reset.
REQ-037 Start, finish=1 mid-RUN, then ap_done -> frozen=1, done_cnt stays 0, state frozen at RUN.
REQ-038 reset=0 asynchronously mid-RUN with CNT_W=4 and start_cnt saturated at 15 -> all outputs 0 before next clock edge.

Source files
------------

// File: rtl/nodf_module_intf.sv
// Transaction monitor for a non-dataflow ap_ctrl handshake: tracks start/done/ready
// activity, busy time and per-transaction latency, with a sticky freeze on finish.
module nodf_module_intf #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   input  logic             ap_continue,
   input  logic             finish,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] start_cnt,
   output logic [CNT_W-1:0] done_cnt,
   output logic [CNT_W-1:0] ready_cnt,
   output logic [CNT_W-1:0] busy_cycles,
   output logic [CNT_W-1:0] last_latency,
   output logic [CNT_W-1:0] max_latency,
   output logic             proto_err,
   output logic             frozen
);

   // state     | meaning
   // ST_IDLE   | waiting for ap_start
   // ST_RUN    | transaction accepted, waiting for ap_done
   // ST_DWAIT  | done seen, waiting for ap_continue
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DWAIT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + ONE;
   endfunction

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_start_cnt;
   logic [CNT_W-1:0] r_done_cnt;
   logic [CNT_W-1:0] r_ready_cnt;
   logic [CNT_W-1:0] r_busy;
   logic [CNT_W-1:0] r_last_lat;
   logic [CNT_W-1:0] r_max_lat;
   logic [CNT_W-1:0] r_lat;
   logic             r_proto_err;
   logic             r_frozen;

   logic             w_start_acc;
   logic             w_done_acc;
   logic             w_lat_load;
   logic             w_lat_inc;
   logic             w_busy_inc;
   logic             w_proto;
   logic [CNT_W-1:0] w_lat_done;

   always_comb begin
      w_state_nxt = r_state;
      w_start_acc = 1'b0;
      w_done_acc  = 1'b0;
      w_lat_load  = 1'b0;
      w_lat_inc   = 1'b0;
      w_busy_inc  = 1'b0;
      w_proto     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (ap_start) begin
               w_start_acc = 1'b1;
               if (ap_done) begin
                  w_done_acc  = 1'b1;
                  w_state_nxt = ap_continue ? ST_IDLE : ST_DWAIT;
               end else begin
                  w_lat_load  = 1'b1;
                  w_state_nxt = ST_RUN;
               end
            end else if (ap_done) begin
               w_proto = 1'b1;
            end
         end
         ST_RUN: begin
            w_busy_inc = 1'b1;
            if (ap_done) begin
               w_done_acc  = 1'b1;
               w_state_nxt = ap_continue ? ST_IDLE : ST_DWAIT;
            end else begin
               w_lat_inc = 1'b1;
            end
         end
         ST_DWAIT: begin
            w_busy_inc = 1'b1;
            if (ap_continue) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // A start and done in the same IDLE cycle is a single-cycle transaction.
   assign w_lat_done = (r_state == ST_IDLE) ? ONE : f_sat_inc(r_lat);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else if (!r_frozen) begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_start_cnt <= '0;
         r_done_cnt  <= '0;
         r_ready_cnt <= '0;
         r_busy      <= '0;
         r_last_lat  <= '0;
         r_max_lat   <= '0;
         r_lat       <= '0;
         r_proto_err <= 1'b0;
         r_frozen    <= 1'b0;
      end else if (!r_frozen) begin
         if (finish)      r_frozen    <= 1'b1;
         if (w_start_acc) r_start_cnt <= f_sat_inc(r_start_cnt);
         if (ap_ready)    r_ready_cnt <= f_sat_inc(r_ready_cnt);
         if (w_busy_inc)  r_busy      <= f_sat_inc(r_busy);
         if (w_proto)     r_proto_err <= 1'b1;
         if (w_lat_load)  r_lat       <= ONE;
         else if (w_lat_inc) r_lat    <= f_sat_inc(r_lat);
         if (w_done_acc) begin
            r_done_cnt <= f_sat_inc(r_done_cnt);
            r_last_lat <= w_lat_done;
            if (w_lat_done > r_max_lat) r_max_lat <= w_lat_done;
         end
      end
   end

   assign state        = r_state;
   assign start_cnt    = r_start_cnt;
   assign done_cnt     = r_done_cnt;
   assign ready_cnt    = r_ready_cnt;
   assign busy_cycles  = r_busy;
   assign last_latency = r_last_lat;
   assign max_latency  = r_max_lat;
   assign proto_err    = r_proto_err;
   assign frozen       = r_frozen;

endmodule

// File: tb/tb_nodf_module_intf.sv
// Directed bench for nodf_module_intf with a narrow counter width so saturation is reachable.
module tb_nodf_module_intf;

   localparam int CNT_W = 4;

   logic             clock = 1'b0;
   logic             reset;
   logic             ap_start, ap_ready, ap_done, ap_continue, finish;
   logic [1:0]       state;
   logic [CNT_W-1:0] start_cnt, done_cnt, ready_cnt, busy_cycles;
   logic [CNT_W-1:0] last_latency, max_latency;
   logic             proto_err, frozen;

   int n_vec = 0;
   int n_err = 0;

   nodf_module_intf #(.CNT_W(CNT_W)) dut (
      .clock        (clock),
      .reset        (reset),
      .ap_start     (ap_start),
      .ap_ready     (ap_ready),
      .ap_done      (ap_done),
      .ap_continue  (ap_continue),
      .finish       (finish),
      .state        (state),
      .start_cnt    (start_cnt),
      .done_cnt     (done_cnt),
      .ready_cnt    (ready_cnt),
      .busy_cycles  (busy_cycles),
      .last_latency (last_latency),
      .max_latency  (max_latency),
      .proto_err    (proto_err),
      .frozen       (frozen)
   );

   always #5 clock = ~clock;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      ap_start    = 1'b0;
      ap_ready    = 1'b0;
      ap_done     = 1'b0;
      ap_continue = 1'b1;
      finish      = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   // Start pulse, idle cycles, done pulse with continue=1: latency lat (>=2).
   task automatic txn(input int lat);
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      for (int i = 0; i < lat - 2; i++) tick();
      ap_done = 1'b1;
      tick();
      ap_done = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk_val({tag, " state"}, 32'(state), 0);
      chk_val({tag, " start"}, 32'(start_cnt), 0);
      chk_val({tag, " done"}, 32'(done_cnt), 0);
      chk_val({tag, " ready"}, 32'(ready_cnt), 0);
      chk_val({tag, " busy"}, 32'(busy_cycles), 0);
      chk_val({tag, " last"}, 32'(last_latency), 0);
      chk_val({tag, " max"}, 32'(max_latency), 0);
      chk_val({tag, " perr"}, 32'(proto_err), 0);
      chk_val({tag, " frozen"}, 32'(frozen), 0);
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      #2;
      do_reset();
      chk_all_zero("rst");

      // single transaction, latency 5
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      chk_val("t1 run", 32'(state), 1);
      tick(); tick(); tick();
      ap_done = 1'b1;
      tick();
      ap_done = 1'b0;
      chk_val("t1 start", 32'(start_cnt), 1);
      chk_val("t1 done", 32'(done_cnt), 1);
      chk_val("t1 last", 32'(last_latency), 5);
      chk_val("t1 max", 32'(max_latency), 5);
      chk_val("t1 state", 32'(state), 0);
      chk_val("t1 busy", 32'(busy_cycles), 4);

      // latencies 3, 7, then 2
      do_reset();
      txn(3);
      txn(7);
      chk_val("t2 done", 32'(done_cnt), 2);
      chk_val("t2 last", 32'(last_latency), 7);
      chk_val("t2 max", 32'(max_latency), 7);
      txn(2);
      chk_val("t2b last", 32'(last_latency), 2);
      chk_val("t2b max", 32'(max_latency), 7);
      chk_val("t2b start", 32'(start_cnt), 3);
      chk_val("t2b busy", 32'(busy_cycles), 9);

      // DONE_WAIT for 4 cycles; held start and repeated done ignored there
      do_reset();
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      tick();
      ap_done = 1'b1;
      ap_continue = 1'b0;
      tick();
      ap_done = 1'b0;
      chk_val("t3 dw0", 32'(state), 2);
      for (int i = 0; i < 3; i++) begin
         ap_start = (i == 0);
         ap_done  = (i == 1);
         tick();
         chk_val("t3 dw", 32'(state), 2);
      end
      ap_start = 1'b0;
      ap_done = 1'b0;
      ap_continue = 1'b1;
      tick();
      chk_val("t3 idle", 32'(state), 0);
      chk_val("t3 busy", 32'(busy_cycles), 6);
      chk_val("t3 last", 32'(last_latency), 3);
      chk_val("t3 done", 32'(done_cnt), 1);
      chk_val("t3 start", 32'(start_cnt), 1);

      // done without start in IDLE
      do_reset();
      ap_done = 1'b1;
      tick();
      ap_done = 1'b0;
      chk_val("t4 perr", 32'(proto_err), 1);
      chk_val("t4 done", 32'(done_cnt), 0);
      chk_val("t4 start", 32'(start_cnt), 0);
      chk_val("t4 state", 32'(state), 0);
      txn(3);
      chk_val("t4 perr sticky", 32'(proto_err), 1);
      chk_val("t4 done2", 32'(done_cnt), 1);

      // start and done in the same IDLE cycle; ready counting
      do_reset();
      chk_val("t5 perr clr", 32'(proto_err), 0);
      ap_start = 1'b1;
      ap_done = 1'b1;
      ap_ready = 1'b1;
      tick();
      chk_val("t5 state", 32'(state), 0);
      chk_val("t5 start", 32'(start_cnt), 1);
      chk_val("t5 done", 32'(done_cnt), 1);
      chk_val("t5 last", 32'(last_latency), 1);
      ap_continue = 1'b0;
      tick();
      ap_start = 1'b0;
      ap_done = 1'b0;
      chk_val("t5 dw", 32'(state), 2);
      chk_val("t5 start2", 32'(start_cnt), 2);
      ap_continue = 1'b1;
      tick();
      ap_ready = 1'b0;
      chk_val("t5 idle", 32'(state), 0);
      chk_val("t5 ready", 32'(ready_cnt), 3);
      chk_val("t5 busy", 32'(busy_cycles), 1);

      // finish mid-RUN freezes everything
      do_reset();
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      tick(); tick();
      finish = 1'b1;
      tick();
      finish = 1'b0;
      chk_val("t6 frozen", 32'(frozen), 1);
      ap_done = 1'b1;
      ap_ready = 1'b1;
      tick(); tick();
      ap_done = 1'b0;
      ap_ready = 1'b0;
      chk_val("t6 done", 32'(done_cnt), 0);
      chk_val("t6 state", 32'(state), 1);
      chk_val("t6 busy", 32'(busy_cycles), 3);
      chk_val("t6 ready", 32'(ready_cnt), 0);
      chk_val("t6 frozen2", 32'(frozen), 1);

      // reset mid-transaction discards it
      do_reset();
      chk_val("t7 unfrozen", 32'(frozen), 0);
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      tick();
      do_reset();
      tick();
      chk_val("t7 state", 32'(state), 0);
      chk_val("t7 done", 32'(done_cnt), 0);

      // saturation at 15
      for (int i = 0; i < 17; i++) begin
         ap_start = 1'b1;
         ap_done = 1'b1;
         tick();
      end
      ap_start = 1'b0;
      ap_done = 1'b0;
      chk_val("t8 start sat", 32'(start_cnt), 15);
      chk_val("t8 done sat", 32'(done_cnt), 15);
      ap_ready = 1'b1;
      for (int i = 0; i < 18; i++) tick();
      ap_ready = 1'b0;
      chk_val("t8 ready sat", 32'(ready_cnt), 15);
      txn(20);
      chk_val("t8 last sat", 32'(last_latency), 15);
      chk_val("t8 max sat", 32'(max_latency), 15);
      chk_val("t8 busy sat", 32'(busy_cycles), 15);
      chk_val("t8 state", 32'(state), 0);

      // asynchronous reset mid-RUN, checked before the next clock edge
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      chk_val("t9 run", 32'(state), 1);
      #3;
      reset = 1'b0;
      #1;
      chk_all_zero("t9 async");
      tick();
      reset = 1'b1;
      tick();
      chk_val("t9 post state", 32'(state), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
